fwd_scoreboard: RTL and testbench

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard.sv | 192 +++++++++++++++++++
 tb/tb_fwd_scoreboard.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: hazard unit for a 5-stage pipeline. It keeps a shadow copy of
// the E/M/W destination info and derives operand-forwarding selects and the
// D-stage stall from the instruction sitting in D.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   d_valid                    D holds a real instruction
//   d_rs, d_rt                 D source addresses
//   d_tuse_rs, d_tuse_rt       cycles until operand is consumed (all-ones = unused)
//   d_we, d_a3, d_tnew         D destination write enable / address / result latency
//   d_md, d_md_div, d_md_start MDU use / divide select / launch
//   stall                      freeze PC/IF/D and bubble E
//   fwd_rs_d, fwd_rt_d         D operand select: 0 regfile, 1 M, 2 W, 3 E
//   fwd_rs_e, fwd_rt_e         E operand select: 0 pipe reg, 1 M, 2 W
//   fwd_rt_m                   M store data from W
//   md_busy                    MDU operation in flight
//
// Build option: define FWD_MDU_EN to include the multiply/divide busy tracker.
// Without it md_busy is tied low and the d_md* inputs are ignored.
module fwd_scoreboard #(
  parameter int AW       = 5,
  parameter int TW       = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic          d_we,
  input  logic [AW-1:0] d_a3,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_md,
  input  logic          d_md_div,
  input  logic          d_md_start,
  output logic          stall,
  output logic [1:0]    fwd_rs_d,
  output logic [1:0]    fwd_rt_d,
  output logic [1:0]    fwd_rs_e,
  output logic [1:0]    fwd_rt_e,
  output logic          fwd_rt_m,
  output logic          md_busy
);

  localparam logic [TW-1:0] TUSE_NONE = '1;

  // Shadow pipeline. W carries no tnew: anything that reached W is ready.
  logic          e_valid_reg, e_we_reg;
  logic [AW-1:0] e_a3_reg, e_rs_reg, e_rt_reg;
  logic [TW-1:0] e_tnew_reg;
  logic          m_valid_reg, m_we_reg;
  logic [AW-1:0] m_a3_reg, m_rt_reg;
  logic [TW-1:0] m_tnew_reg;
  logic          w_valid_reg, w_we_reg;
  logic [AW-1:0] w_a3_reg;

  logic          data_stall;
  logic          md_stall;
  logic          stall_int;

  function automatic logic is_prod(input logic v, input logic we,
                                   input logic [AW-1:0] a3, input logic [AW-1:0] x);
    return v && we && (a3 == x) && (x != '0);
  endfunction

  // Operand index 0 = rs, 1 = rt.
  logic [1:0][AW-1:0] d_src, e_src;
  logic [1:0][TW-1:0] d_tuse;
  logic [1:0][1:0]    fwd_d, fwd_e;
  logic [1:0]         stall_op;

  assign d_src  = {d_rt, d_rs};
  assign e_src  = {e_rt_reg, e_rs_reg};
  assign d_tuse = {d_tuse_rt, d_tuse_rs};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op
      logic e_hit, m_hit, w_hit;
      logic em_hit, ew_hit;

      assign e_hit = is_prod(e_valid_reg, e_we_reg, e_a3_reg, d_src[gi]);
      assign m_hit = is_prod(m_valid_reg, m_we_reg, m_a3_reg, d_src[gi]);
      assign w_hit = is_prod(w_valid_reg, w_we_reg, w_a3_reg, d_src[gi]);

      // The nearest producer owns the value; if it is not ready yet we do not
      // fall through to an older (stale) copy -- the stall or a later-stage
      // forward covers that case.
      assign fwd_d[gi] = e_hit ? ((e_tnew_reg == '0) ? 2'd3 : 2'd0) :
                         m_hit ? ((m_tnew_reg == '0) ? 2'd1 : 2'd0) :
                         w_hit ? 2'd2 : 2'd0;

      assign stall_op[gi] = (d_tuse[gi] != TUSE_NONE) &&
                            (e_hit ? (e_tnew_reg > d_tuse[gi])
                                   : (m_hit && (m_tnew_reg > d_tuse[gi])));

      assign em_hit = is_prod(m_valid_reg, m_we_reg, m_a3_reg, e_src[gi]);
      assign ew_hit = is_prod(w_valid_reg, w_we_reg, w_a3_reg, e_src[gi]);

      assign fwd_e[gi] = em_hit ? ((m_tnew_reg == '0) ? 2'd1 : 2'd0) :
                         ew_hit ? 2'd2 : 2'd0;
    end
  endgenerate

  assign fwd_rs_d = fwd_d[0];
  assign fwd_rt_d = fwd_d[1];
  assign fwd_rs_e = fwd_e[0];
  assign fwd_rt_e = fwd_e[1];
  assign fwd_rt_m = is_prod(w_valid_reg, w_we_reg, w_a3_reg, m_rt_reg);

  // Outputs fall to zero during reset without explicit gating: all shadow
  // state and the MDU counter are cleared asynchronously.
  assign data_stall = d_valid && (|stall_op);
  assign stall_int  = data_stall || md_stall;
  assign stall      = stall_int;

`ifdef FWD_MDU_EN
  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  logic [CW-1:0] md_cnt_reg;

  assign md_busy = (md_cnt_reg != '0);
  // A start is itself an MDU use, so a start while busy always waits.
  assign md_stall = d_valid && (d_md || d_md_start) && md_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_reg <= '0;
    end else if (d_valid && d_md_start && !stall_int) begin
      md_cnt_reg <= d_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (md_cnt_reg != '0) begin
      md_cnt_reg <= md_cnt_reg - CW'(1);
    end
  end
`else
  localparam int unused_cyc = MULT_CYC + DIV_CYC;
  logic unused_md;
  assign unused_md = ^{d_md, d_md_div, d_md_start};
  assign md_busy   = 1'b0;
  assign md_stall  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid_reg <= 1'b0;
      e_we_reg    <= 1'b0;
      e_a3_reg    <= '0;
      e_rs_reg    <= '0;
      e_rt_reg    <= '0;
      e_tnew_reg  <= '0;
      m_valid_reg <= 1'b0;
      m_we_reg    <= 1'b0;
      m_a3_reg    <= '0;
      m_rt_reg    <= '0;
      m_tnew_reg  <= '0;
      w_valid_reg <= 1'b0;
      w_we_reg    <= 1'b0;
      w_a3_reg    <= '0;
    end else begin
      w_valid_reg <= m_valid_reg;
      w_we_reg    <= m_we_reg;
      w_a3_reg    <= m_a3_reg;

      m_valid_reg <= e_valid_reg;
      m_we_reg    <= e_we_reg;
      m_a3_reg    <= e_a3_reg;
      m_rt_reg    <= e_rt_reg;
      m_tnew_reg  <= (e_tnew_reg != '0) ? e_tnew_reg - TW'(1) : '0;

      if (d_valid && !stall_int) begin
        e_valid_reg <= 1'b1;
        e_we_reg    <= d_we;
        e_a3_reg    <= d_a3;
        e_rs_reg    <= d_rs;
        e_rt_reg    <= d_rt;
        e_tnew_reg  <= d_tnew;
      end else begin
        e_valid_reg <= 1'b0;
        e_we_reg    <= 1'b0;
        e_a3_reg    <= '0;
        e_rs_reg    <= '0;
        e_rt_reg    <= '0;
        e_tnew_reg  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;
  localparam int AW = 5;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          d_valid;
  logic [AW-1:0] d_rs, d_rt, d_a3;
  logic [TW-1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic          d_we, d_md, d_md_div, d_md_start;
  logic          stall, fwd_rt_m, md_busy;
  logic [1:0]    fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_scoreboard #(.AW(AW), .TW(TW), .MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_we(d_we), .d_a3(d_a3), .d_tnew(d_tnew),
    .d_md(d_md), .d_md_div(d_md_div), .d_md_start(d_md_start),
    .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m),
    .md_busy(md_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d_set(input logic v, input logic [AW-1:0] rs, input logic [TW-1:0] tu_rs,
                       input logic [AW-1:0] rt, input logic [TW-1:0] tu_rt,
                       input logic we, input logic [AW-1:0] a3, input logic [TW-1:0] tnew);
    d_valid = v;   d_rs = rs;   d_tuse_rs = tu_rs;
    d_rt = rt;     d_tuse_rt = tu_rt;
    d_we = we;     d_a3 = a3;   d_tnew = tnew;
    d_md = 1'b0;   d_md_div = 1'b0;  d_md_start = 1'b0;
    #1;
  endtask

  task automatic d_idle();
    d_set(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_fwd_rs_d"}, fwd_rs_d, 0);
    chk({tag, "_fwd_rt_d"}, fwd_rt_d, 0);
    chk({tag, "_fwd_rs_e"}, fwd_rs_e, 0);
    chk({tag, "_fwd_rt_e"}, fwd_rt_e, 0);
    chk({tag, "_fwd_rt_m"}, fwd_rt_m, 0);
    chk({tag, "_md_busy"}, md_busy, 0);
  endtask

  initial begin
    // Reset with a hazardous-looking D instruction present.
    rst_n = 1'b0;
    d_set(1'b1, 5'd8, 2'd0, 5'd8, 2'd0, 1'b1, 5'd8, 2'd1);
    tick();
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;
    d_idle();
    tick();

    // Load-use: lw $8 (tnew=1) then add rs=$8 tuse=0.
    d_set(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd8, 2'd1);
    chk("lw_issue_stall", stall, 0);
    tick();
    d_set(1'b1, 5'd8, 2'd0, 5'd0, 2'd3, 1'b1, 5'd10, 2'd0);
    chk("ld_use_stall", stall, 1);
    tick();
    chk("ld_use_release", stall, 0);
    chk("ld_use_fwd_m", fwd_rs_d, 1);
    tick();
    // E=add a3=10 rs=8, M=bubble, W=lw a3=8.
    d_set(1'b1, 5'd10, 2'd0, 5'd8, 2'd1, 1'b0, 5'd0, 2'd0);
    chk("fwd_d_e", fwd_rs_d, 3);
    chk("fwd_d_w", fwd_rt_d, 2);
    chk("fwd_e_w", fwd_rs_e, 2);
    chk("fwd_e_none", fwd_rt_e, 0);
    chk("fwd_d_nostall", stall, 0);
    tick();
    // E rs=10 rt=8, M=add a3=10 tnew=0, W=bubble.
    d_idle();
    chk("fwd_e_m", fwd_rs_e, 1);
    chk("fwd_e_rt_none", fwd_rt_e, 0);
    tick(); tick(); tick();

    // Producer with tnew=2: stalls a tuse=0 consumer in E and again in M.
    d_set(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd7, 2'd2);
    tick();
    d_set(1'b1, 5'd7, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0);
    chk("m_stall_e", stall, 1);
    tick();
    chk("m_stall_m", stall, 1);
    tick();
    chk("m_stall_rel", stall, 0);
    chk("fwd_d_w2", fwd_rs_d, 2);
    d_set(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd7, 2'd2);
    tick();
    d_set(1'b0, 5'd7, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0);
    chk("novalid_stall", stall, 0);
    d_set(1'b1, 5'd7, 2'd1, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0);
    chk("tuse1_stall", stall, 1);
    tick();
    chk("tuse1_rel", stall, 0);
    tick();
    d_idle();
    tick(); tick(); tick();

    // Nearer ready producer in E hides a not-ready one in M.
    d_set(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd11, 2'd3);
    tick();
    d_set(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd11, 2'd0);
    tick();
    d_set(1'b1, 5'd11, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0);
    chk("near_e_wins", stall, 0);
    chk("near_e_fwd", fwd_rs_d, 3);
    tick();
    d_idle();
    tick(); tick(); tick();

    // Two addu to $9: E beats M, then M beats W at both D and E.
    d_set(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd9, 2'd0);
    tick();
    d_set(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd9, 2'd0);
    tick();
    d_set(1'b1, 5'd9, 2'd0, 5'd9, 2'd0, 1'b0, 5'd0, 2'd0);
    chk("e_over_m_rs", fwd_rs_d, 3);
    chk("e_over_m_rt", fwd_rt_d, 3);
    chk("e_over_m_stall", stall, 0);
    tick();
    d_set(1'b1, 5'd9, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0);
    chk("fwd_d_m_over_w", fwd_rs_d, 1);
    chk("fwd_e_m_over_w_rs", fwd_rs_e, 1);
    chk("fwd_e_m_over_w_rt", fwd_rt_e, 1);
    tick();
    d_idle();
    tick(); tick(); tick();

    // Writes to $0 in E/M/W never forward or stall.
    d_set(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0);
    tick();
    tick();
    d_set(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd3);
    tick();
    d_set(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0);
    chk("zero_fwd_rs", fwd_rs_d, 0);
    chk("zero_fwd_rt", fwd_rt_d, 0);
    chk("zero_stall", stall, 0);
    tick();
    d_idle();
    tick(); tick(); tick();

    // Store data forwarding: addu $5 then sw rt=$5.
    d_set(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd5, 2'd0);
    tick();
    d_set(1'b1, 5'd0, 2'd3, 5'd5, 2'd2, 1'b0, 5'd0, 2'd0);
    chk("sw_fwd_d", fwd_rt_d, 3);
    chk("sw_stall", stall, 0);
    tick();
    d_idle();
    chk("sw_fwd_e", fwd_rt_e, 1);
    tick();
    chk("fwd_m_hit", fwd_rt_m, 1);
    tick();
    d_set(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd6, 2'd0);
    tick();
    d_set(1'b1, 5'd0, 2'd3, 5'd5, 2'd2, 1'b0, 5'd0, 2'd0);
    tick();
    d_idle();
    tick();
    chk("fwd_m_miss", fwd_rt_m, 0);
    tick(); tick();

`ifdef FWD_MDU_EN
    // mult start, then mflo waits 5 cycles; divide waits 10.
    d_set(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0);
    d_md = 1'b1; d_md_start = 1'b1; d_md_div = 1'b0;
    #1;
    chk("mult_start_stall", stall, 0);
    tick();
    d_set(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd2, 2'd0);
    d_md = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("mult_busy", md_busy, 1);
      chk("mult_stall", stall, 1);
      tick();
    end
    chk("mult_done_busy", md_busy, 0);
    chk("mult_done_stall", stall, 0);
    d_set(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0);
    d_md = 1'b1; d_md_start = 1'b1; d_md_div = 1'b1;
    #1;
    chk("div_start_stall", stall, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("div_busy", md_busy, 1);
      chk("div_restart_stall", stall, 1);
      tick();
    end
    chk("div_done_busy", md_busy, 0);
    chk("div_done_stall", stall, 0);
    tick();
    d_idle();
    tick(); tick(); tick();
`else
    d_set(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0);
    d_md = 1'b1; d_md_start = 1'b1; d_md_div = 1'b1;
    #1;
    chk("nomdu_stall", stall, 0);
    tick();
    d_md_start = 1'b0;
    #1;
    chk("nomdu_busy", md_busy, 0);
    chk("nomdu_stall2", stall, 0);
    tick();
    d_idle();
    tick(); tick(); tick();
`endif

    // Reset mid-operation with a load-use hazard pending.
`ifdef FWD_MDU_EN
    d_set(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0);
    d_md = 1'b1; d_md_start = 1'b1; d_md_div = 1'b1;
    #1;
    tick();
`endif
    d_set(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd8, 2'd1);
    tick();
    d_set(1'b1, 5'd8, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0);
    chk("pre_rst_stall", stall, 1);
`ifdef FWD_MDU_EN
    chk("pre_rst_busy", md_busy, 1);
`endif
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_stall", stall, 0);
    chk("post_rst_fwd", fwd_rs_d, 0);
    chk("post_rst_busy", md_busy, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
